// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state, bubble-latency
// limits and the bundled control-output type.
package pipe_hazard_ctrl_pkg;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;
  localparam int LU_CNT_W     = 2;

  typedef enum logic {
    RUN     = 1'b0,
    LU_HOLD = 1'b1
  } lu_state_e;

  typedef struct packed {
    logic pc_en;
    logic stall_D;
    logic flush_D;
    logic stall_E;
    logic flush_E;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, stall_D: 1'b0, flush_D: 1'b0, stall_E: 1'b0, flush_E: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, stall_D: 1'b0, flush_D: 1'b1, stall_E: 1'b0, flush_E: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, stall_D: 1'b1, flush_D: 1'b0, stall_E: 1'b1, flush_E: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, stall_D: 1'b0, flush_D: 1'b1, stall_E: 1'b0, flush_E: 1'b1};
  localparam ctrl_t CTRL_LOADUSE = '{pc_en: 1'b0, stall_D: 1'b1, flush_D: 1'b0, stall_E: 1'b0, flush_E: 1'b1};
  localparam ctrl_t CTRL_NOFETCH = '{pc_en: 1'b0, stall_D: 1'b0, flush_D: 1'b1, stall_E: 1'b0, flush_E: 1'b0};

  // Out-of-range latencies are pulled into the legal window rather than
  // letting the 2-bit hold counter wrap.
  function automatic int clamp_load_lat(input int lat);
    if (lat < LOAD_LAT_MIN) return LOAD_LAT_MIN;
    if (lat > LOAD_LAT_MAX) return LOAD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage inputs in, stall/flush
// controls and performance counters out. All signals are level, per-cycle.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_D;
  logic [4:0]       rs2_D;
  logic             rs1_used_D;
  logic             rs2_used_D;
  logic [4:0]       rd_E;
  logic             memread_E;
  logic             branch_taken_E;
  logic             imem_valid;
  logic             dmem_req_M;
  logic             dmem_ready;
  logic             cnt_clr;

  logic             pc_en;
  logic             stall_D;
  logic             flush_D;
  logic             stall_E;
  logic             flush_E;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  // The pipeline datapath drives stage status and consumes the controls.
  modport master (
    output rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, memread_E,
           branch_taken_E, imem_valid, dmem_req_M, dmem_ready, cnt_clr,
    input  pc_en, stall_D, flush_D, stall_E, flush_E, stall_cnt, redirect_cnt
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, memread_E,
           branch_taken_E, imem_valid, dmem_req_M, dmem_ready, cnt_clr,
    output pc_en, stall_D, flush_D, stall_E, flush_E, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: resolves memory freeze, branch
// redirect, load-use bubbles and fetch misses into PC/IF-ID/ID-EX controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   hz,
  output lu_state_e           dbg_state_o,
  output logic [LU_CNT_W-1:0] dbg_lu_cnt_o
);

  localparam int                LAT_C   = clamp_load_lat(LOAD_LAT);
  localparam logic [LU_CNT_W-1:0] LU_INIT = (LAT_C > 1) ? LU_CNT_W'(LAT_C - 2) : '0;

  lu_state_e           state_q, state_d;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  ctrl_t               ctrl;
  logic                lu_hit;
  logic                freeze;
  logic                redirect;

  assign lu_hit = hz.memread_E && (hz.rd_E != 5'd0) &&
                  ((hz.rs1_used_D && (hz.rs1_D == hz.rd_E)) ||
                   (hz.rs2_used_D && (hz.rs2_D == hz.rd_E)));
  assign freeze = hz.dmem_req_M && !hz.dmem_ready;

  // Priority chain: freeze > branch > load-use (new or held) > fetch miss > normal.
  // Reset is folded in so the outputs are defined while rst_n is low.
  always_comb begin
    ctrl     = CTRL_NORMAL;
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    redirect = 1'b0;
    if (!rst_n) begin
      ctrl     = CTRL_RESET;
      state_d  = RUN;
      lu_cnt_d = '0;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (hz.branch_taken_E) begin
      ctrl     = CTRL_BRANCH;
      state_d  = RUN;
      lu_cnt_d = '0;
      redirect = 1'b1;
    end else if (state_q == LU_HOLD) begin
      ctrl = CTRL_LOADUSE;
      if (lu_cnt_q == '0) begin
        state_d = RUN;
      end else begin
        lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
      end
    end else if (lu_hit) begin
      ctrl = CTRL_LOADUSE;
      if (LAT_C > 1) begin
        state_d  = LU_HOLD;
        lu_cnt_d = LU_INIT;
      end
    end else if (!hz.imem_valid) begin
      ctrl = CTRL_NOFETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign hz.pc_en   = ctrl.pc_en;
  assign hz.stall_D = ctrl.stall_D;
  assign hz.flush_D = ctrl.flush_D;
  assign hz.stall_E = ctrl.stall_E;
  assign hz.flush_E = ctrl.flush_E;

  assign dbg_state_o  = state_q;
  assign dbg_lu_cnt_o = lu_cnt_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (hz.cnt_clr),
    .inc_i (!ctrl.pc_en),
    .cnt_o (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (hz.cnt_clr),
    .inc_i (redirect),
    .cnt_o (hz.redirect_cnt)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, load-use bubble cycles (legal 1..3).
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rs1_D, rs2_D  in  5 each  source registers of the instruction in decode.
REQ-006 SHALL have ports rs1_used_D, rs2_used_D  in  1 each  the decode instruction reads that source.
REQ-007 SHALL have port rd_E  in  5  destination register of the instruction in execute.
REQ-008 SHALL have port memread_E  in  1  the instruction in execute is a load.
REQ-009 SHALL have port branch_taken_E  in  1  the instruction in execute redirects the PC.
REQ-010 SHALL have port imem_valid  in  1  the instruction word at fetch is valid this cycle.
REQ-011 SHALL have ports dmem_req_M, dmem_ready  in  1 each  memory-stage access pending / completing.
REQ-012 SHALL have port cnt_clr  in  1  synchronous clear of both counters.
REQ-013 SHALL have ports pc_en, stall_D, flush_D, stall_E, flush_E  out  1 each  PC write enable, IF/ID hold, IF/ID clear, ID/EX-and-later hold, ID/EX bubble.
REQ-014 SHALL have ports stall_cnt, redirect_cnt  out  CNT_W each  performance counters.

Function
REQ-015 SHALL define lu_hit = memread_E & (rd_E!=0) & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E)).
REQ-016 SHALL define freeze = dmem_req_M & ~dmem_ready.
REQ-017 SHALL implement FSM states RUN and LU_HOLD with a down-counter lu_cnt of width 2.
REQ-018 SHALL apply this fixed priority each cycle: freeze > branch_taken_E > (lu_hit in RUN or state LU_HOLD) > ~imem_valid > normal.
REQ-019 Freeze SHALL drive pc_en=0, stall_D=1, stall_E=1, flush_D=0, flush_E=0, and hold FSM state and lu_cnt unchanged.
REQ-020 Branch, when not frozen, SHALL drive pc_en=1, flush_D=1, flush_E=1, stall_D=0, stall_E=0; next state RUN, lu_cnt=0.
REQ-021 lu_hit in RUN SHALL drive pc_en=0, stall_D=1, flush_E=1, flush_D=0, stall_E=0; if LOAD_LAT>1 next state LU_HOLD with lu_cnt=LOAD_LAT-2, else stay RUN.
REQ-022 LU_HOLD SHALL drive the REQ-021 outputs; at lu_cnt==0 next state RUN, else decrement lu_cnt.
REQ-023 ~imem_valid alone SHALL drive pc_en=0, flush_D=1, stall_D=0, stall_E=0, flush_E=0.
REQ-024 Normal SHALL drive pc_en=1 and all stall/flush outputs 0.
REQ-025 stall_D and flush_D SHALL never both be 1 in the same cycle.
REQ-026 stall_cnt SHALL increment on every non-reset cycle with pc_en=0; redirect_cnt SHALL increment on every cycle where REQ-020 applies.
REQ-027 Both counters SHALL saturate at all-ones, never wrap.
REQ-028 cnt_clr SHALL zero both counters on the next edge and SHALL override a same-cycle increment.

Reset
REQ-029 While rst_n=0, state SHALL be RUN, lu_cnt=0, counters=0.
REQ-030 While rst_n=0, outputs SHALL be pc_en=0, flush_D=1, flush_E=1, stall_D=0, stall_E=0, independent of all other inputs.
REQ-031 Reset asserted in LU_HOLD or during a freeze SHALL abort it immediately; the first cycle after release SHALL obey REQ-018 from RUN.

Structure
REQ-032 The state enum and the LOAD_LAT legal-range constants SHALL live in the shared pipeline package.
REQ-033 The two saturating counters SHALL be instances of one sub-module, sat_counter.
REQ-034 All outputs except the counters SHALL be combinational from state, lu_cnt, inputs and rst_n.

Verification
REQ-035 LOAD_LAT=1: memread_E=1, rd_E=5, rs1_D=5, rs1_used_D=1 for one cycle -> exactly one cycle of pc_en=0, stall_D=1, flush_E=1; stall_cnt=1.
REQ-036 LOAD_LAT=3, same hazard -> three consecutive bubble cycles (RUN, LU_HOLD, LU_HOLD), then pc_en=1.
REQ-037 Same-cycle branch_taken_E=1 with lu_hit=1 -> flush_D=1, flush_E=1, pc_en=1, stall_D=0; redirect_cnt=1.
REQ-038 dmem_req_M=1, dmem_ready=0 for 4 cycles during LU_HOLD (lu_cnt=1) -> 4 freeze cycles, lu_cnt still 1, then LU_HOLD resumes.
REQ-039 rd_E=0 with memread_E=1 and rs1_D=0 -> no stall; imem_valid=0 -> flush_D=1, pc_en=0.
REQ-040 Preload stall_cnt to all-ones via forced stalls (CNT_W=4: 15 cycles), one more stall -> value stays 15; cnt_clr with a stall -> 0.
